// File: rtl/pcpi_vec.sv
// rtl/pcpi_vec.sv - PCPI vector coprocessor: vsetvli, strided vector load/store, vmul.vv (SEW=32, LMUL=1)
// Defining PCPI_VEC_DOT_EN adds vdot.vv decode (dot product reduced into vd[0]).
module pcpi_vec #(
  parameter int VLEN = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_cpurs1,
  input  logic [31:0] pcpi_cpurs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int VLMAX = VLEN / 32;
  localparam int VW    = $clog2(VLMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETVL, S_MEM_SETUP, S_MEM_REQ, S_ALU, S_DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_SETVL, OP_LOAD, OP_STORE, OP_MUL, OP_DOT} op_t;

  state_t state, state_next;
  op_t    dec_op, op_q;

  logic [VLEN-1:0] vreg [32];
  logic [VW-1:0]   vl, idx, setvl_vl;
  logic [10:0]     vtype;
  logic [4:0]      vd_q, vs1_q, vs2_q;
  logic [31:0]     stride_q, acc;
  logic [31:0]     src1, src2, prod;
  logic            last, accept;

  logic            vwe;
  logic [4:0]      vwa;
  logic [VW-1:0]   vwi;
  logic [31:0]     vwd;
  logic            unused_ok;

  function automatic logic [31:0] elem(input logic [VLEN-1:0] v, input logic [VW-1:0] i);
    elem = v[32*i +: 32];
  endfunction

  always_comb begin
    dec_op = OP_NONE;
    if (pcpi_insn[6:0] == 7'b1010111) begin
      if (pcpi_insn[14:12] == 3'b111 && !pcpi_insn[31])
        dec_op = OP_SETVL;
      else if (pcpi_insn[14:12] == 3'b000 && pcpi_insn[31:26] == 6'b100101)
        dec_op = OP_MUL;
`ifdef PCPI_VEC_DOT_EN
      else if (pcpi_insn[14:12] == 3'b000 && pcpi_insn[31:26] == 6'b111001)
        dec_op = OP_DOT;
`endif
    end else if ((pcpi_insn[6:0] == 7'b0000111 || pcpi_insn[6:0] == 7'b0100111) &&
                 pcpi_insn[14:13] == 2'b11 &&
                 (pcpi_insn[28:26] == 3'b000 || pcpi_insn[28:26] == 3'b010)) begin
      dec_op = pcpi_insn[5] ? OP_STORE : OP_LOAD;
    end
  end

  assign accept = (state == S_IDLE) && pcpi_valid && (dec_op != OP_NONE);

  // Only vsew=e32 with vlmul=m1 is supported; any other vtype yields vl=0.
  always_comb begin
    setvl_vl = '0;
    if (pcpi_insn[24:22] == 3'b010 && pcpi_insn[21:20] == 2'b00)
      setvl_vl = (pcpi_cpurs1 > 32'(VLMAX)) ? VW'(VLMAX) : pcpi_cpurs1[VW-1:0];
  end

  assign src1 = elem(vreg[vs1_q], idx);
  assign src2 = elem(vreg[vs2_q], idx);
  assign prod = src2 * src1;
  assign last = ((idx + VW'(1)) == vl);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (dec_op == OP_SETVL)                            state_next = S_SETVL;
          else if (vl == '0)                                 state_next = S_DONE;
          else if (dec_op == OP_LOAD || dec_op == OP_STORE)  state_next = S_MEM_SETUP;
          else                                               state_next = S_ALU;
        end
      end
      S_SETVL:     state_next = S_DONE;
      S_MEM_SETUP: state_next = S_MEM_REQ;
      S_MEM_REQ:   if (mem_ready) state_next = last ? S_DONE : S_MEM_SETUP;
      S_ALU:       if (last) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  assign pcpi_wait  = (state != S_IDLE);
  assign pcpi_ready = (state == S_DONE);
  assign pcpi_wr    = pcpi_ready && (op_q == OP_SETVL);
  assign mem_valid  = (state == S_MEM_REQ);
  assign mem_wstrb  = (mem_valid && op_q == OP_STORE) ? 4'hf : 4'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q      <= OP_NONE;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      stride_q  <= '0;
      idx       <= '0;
      acc       <= '0;
      vl        <= '0;
      vtype     <= '0;
      pcpi_rd   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= dec_op;
            vd_q     <= pcpi_insn[11:7];
            vs1_q    <= pcpi_insn[19:15];
            vs2_q    <= pcpi_insn[24:20];
            stride_q <= pcpi_insn[27] ? pcpi_cpurs2 : 32'd4;
            idx      <= '0;
            acc      <= '0;
            if (dec_op == OP_SETVL) begin
              vtype   <= pcpi_insn[30:20];
              vl      <= setvl_vl;
              pcpi_rd <= 32'(setvl_vl);
            end
            if (dec_op == OP_LOAD || dec_op == OP_STORE)
              mem_addr <= pcpi_cpurs1;
          end
        end
        S_MEM_SETUP: begin
          if (op_q == OP_STORE)
            mem_wdata <= elem(vreg[vd_q], idx);
        end
        S_MEM_REQ: begin
          if (mem_ready) begin
            idx      <= idx + VW'(1);
            mem_addr <= mem_addr + stride_q;
          end
        end
        S_ALU: begin
          idx <= idx + VW'(1);
          acc <= acc + prod;
        end
        default: ;
      endcase
    end
  end

  // Single write port; vdot writes only at its last element so every source is read first.
  always_comb begin
    vwe = 1'b0;
    vwa = vd_q;
    vwi = idx;
    vwd = prod;
    if (state == S_MEM_REQ && mem_ready && op_q == OP_LOAD) begin
      vwe = 1'b1;
      vwd = mem_rdata;
    end else if (state == S_ALU && op_q == OP_MUL) begin
      vwe = 1'b1;
    end else if (state == S_ALU && op_q == OP_DOT && last) begin
      vwe = 1'b1;
      vwi = '0;
      vwd = acc + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (vwe) vreg[vwa][32*vwi +: 32] <= vwd;
  end

  assign unused_ok = ^{vtype, pcpi_insn[25]};

endmodule

// File: tb/tb_pcpi_vec.sv
// tb/tb_pcpi_vec.sv - randomized scoreboard bench for pcpi_vec against a behavioural vector model
module tb_pcpi_vec;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_cpurs1, pcpi_cpurs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  pcpi_vec #(.VLEN(256)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_cpurs1(pcpi_cpurs1), .pcpi_cpurs2(pcpi_cpurs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic wr; logic [31:0] rd;} rsp_t;
  typedef struct {logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} mem_t;

  rsp_t exp_rsp[$];
  mem_t exp_mem[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] mreg    [32][8];
  int          mvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_setvl(input logic [10:0] vt);
    return {1'b0, vt, 5'd3, 3'b111, 5'd4, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_vop(input bit dot, input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] vs1);
    logic [5:0] f6;
    f6 = dot ? 6'b111001 : 6'b100101;
    return {f6, 1'b1, vs2, vs1, 3'b000, vd, 7'b1010111};
  endfunction

  function automatic logic [31:0] enc_mem(input bit store, input bit strided, input logic [4:0] vr, input bit w7);
    logic [2:0] width, mop;
    logic [6:0] opc;
    width = w7 ? 3'b111 : 3'b110;
    mop   = strided ? 3'b010 : 3'b000;
    opc   = store ? 7'b0100111 : 7'b0000111;
    return {3'b000, mop, 1'b1, 5'd2, 5'd1, width, vr, opc};
  endfunction

  task automatic push_rsp(input logic wr, input logic [31:0] rd);
    rsp_t r;
    r.wr = wr;
    r.rd = rd;
    exp_rsp.push_back(r);
  endtask

  task automatic run_insn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2, input bit is_setvl);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(posedge clk); #1;
    pcpi_insn = insn; pcpi_cpurs1 = rs1; pcpi_cpurs2 = rs2; pcpi_valid = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (c == 1) chk("wait_after_accept", 32'(pcpi_wait), 32'd1);
      if (pcpi_ready) begin
        got = 1'b1;
        lat = c;
      end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    else if (is_setvl) chk("setvl_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
  endtask

  task automatic do_setvl(input int unsigned avl, input logic [10:0] vt);
    int unsigned nvl;
    nvl = (vt[4:2] == 3'b010 && vt[1:0] == 2'b00) ? ((avl > 8) ? 8 : avl) : 0;
    mvl = int'(nvl);
    push_rsp(1'b1, nvl);
    run_insn(enc_setvl(vt), avl, $urandom, 1'b1);
  endtask

  task automatic do_mem(input bit store, input bit strided, input logic [4:0] vr,
                        input logic [31:0] base, input logic [31:0] stride);
    logic [31:0] eff, a, rs2;
    mem_t e;
    eff = strided ? stride : 32'd4;
    rs2 = strided ? stride : $urandom;
    for (int i = 0; i < mvl; i++) begin
      a = base + eff * 32'(i);
      e.addr = a;
      if (store) begin
        e.wstrb = 4'hf;
        e.wdata = mreg[vr][i];
        ref_mem[a[13:2]] = mreg[vr][i];
      end else begin
        e.wstrb = 4'h0;
        e.wdata = 32'd0;
        mreg[vr][i] = ref_mem[a[13:2]];
      end
      exp_mem.push_back(e);
    end
    push_rsp(1'b0, 32'd0);
    run_insn(enc_mem(store, strided, vr, 1'($urandom_range(0, 1))), base, rs2, 1'b0);
  endtask

  task automatic do_vop(input bit dot, input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] vs1);
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < 8; i++) begin
      a[i] = mreg[vs2][i];
      b[i] = mreg[vs1][i];
    end
    if (dot) begin
      for (int i = 0; i < mvl; i++) sum += a[i] * b[i];
      if (mvl > 0) mreg[vd][0] = sum;
    end else begin
      for (int i = 0; i < mvl; i++) mreg[vd][i] = a[i] * b[i];
    end
    push_rsp(1'b0, 32'd0);
    run_insn(enc_vop(dot, vd, vs2, vs1), $urandom, $urandom, 1'b0);
  endtask

  task automatic run_ignored(input logic [31:0] insn, input string name);
    int seen;
    seen = 0;
    @(posedge clk); #1;
    pcpi_insn = insn; pcpi_cpurs1 = 32'd8; pcpi_cpurs2 = 32'd4; pcpi_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || mem_valid) seen++;
    end
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    chk(name, 32'(seen), 32'd0);
  endtask

  // pcpi response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (resetn && pcpi_ready) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_wr", 32'(pcpi_wr), 32'(r.wr));
          if (r.wr) chk("rsp_rd", pcpi_rd, r.rd);
        end
      end
    end
  end

  // memory responder and bus monitor
  initial begin
    int delay;
    bit prev_ack, prev_valid, cur_ack;
    logic [31:0] prev_addr, prev_wdata;
    mem_t e;
    delay = 0; prev_ack = 1'b0; prev_valid = 1'b0; prev_addr = '0; prev_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      cur_ack = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!resetn) begin
        delay = $urandom_range(0, 2);
      end else begin
        if (prev_ack) begin
          chk("mem_valid_drop", 32'(mem_valid), 32'd0);
        end else if (prev_valid) begin
          chk("mem_valid_hold", 32'(mem_valid), 32'd1);
          chk("mem_addr_stable", mem_addr, prev_addr);
          chk("mem_wdata_stable", mem_wdata, prev_wdata);
        end
        if (mem_valid && !prev_ack) begin
          if (delay == 0) begin
            cur_ack = 1'b1;
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr[13:2]];
            if (mem_wstrb == 4'hf) mem[mem_addr[13:2]] = mem_wdata;
            delay = $urandom_range(0, 2);
            if (exp_mem.size() == 0) begin
              chk("unexpected_mem_access", mem_addr, 32'hffff_ffff);
            end else begin
              e = exp_mem.pop_front();
              chk("mem_addr", mem_addr, e.addr);
              chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
              if (e.wstrb == 4'hf) chk("mem_wdata", mem_wdata, e.wdata);
            end
          end else begin
            delay--;
          end
        end
      end
      prev_ack   = cur_ack;
      prev_valid = resetn && mem_valid;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [31:0] base, stride;
    int sel;
    resetn = 1'b0;
    pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_cpurs1 = '0; pcpi_cpurs2 = '0;
    mvl = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pcpi_wr", 32'(pcpi_wr), 32'd0);
    chk("rst_pcpi_wait", 32'(pcpi_wait), 32'd0);
    chk("rst_pcpi_ready", 32'(pcpi_ready), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_pcpi_rd", pcpi_rd, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;

    // vl resets to 0: a load must complete without touching memory
    do_mem(1'b0, 1'b0, 5'd5, 32'd64, 32'd4);

    do_setvl(8, 11'h008);
    do_setvl(20, 11'h008);
    do_setvl(8, 11'h004);
    do_mem(1'b0, 1'b1, 5'd6, 32'd96, 32'd8);
    do_setvl(3, 11'h008);
    do_setvl(0, 11'h008);

    run_ignored({1'b1, 11'h008, 5'd3, 3'b111, 5'd4, 7'b1010111}, "ign_setvl_bit31");
    run_ignored({6'b100100, 1'b1, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1010111}, "ign_funct6");
    run_ignored({6'b100101, 1'b1, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1010111}, "ign_funct3");
    run_ignored({3'b000, 3'b000, 1'b1, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0000111}, "ign_width");
    run_ignored({3'b000, 3'b001, 1'b1, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0000111}, "ign_mop");
    run_ignored({7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, "ign_opcode");
`ifndef PCPI_VEC_DOT_EN
    run_ignored(enc_vop(1'b1, 5'd8, 5'd2, 5'd1), "ign_vdot_disabled");
`endif

    do_setvl(8, 11'h008);
    for (int i = 0; i < 8; i++) begin
      mem[100 + i] = 32'h201 + 32'h404 * 32'(i);
      ref_mem[100 + i] = mem[100 + i];
      mem[300 + i] = 32'(i + 1);
      ref_mem[300 + i] = mem[300 + i];
    end
    do_mem(1'b0, 1'b1, 5'd1, 32'd400, 32'd4);
    do_mem(1'b1, 1'b1, 5'd1, 32'd2000, 32'd4);
    do_mem(1'b0, 1'b0, 5'd1, 32'd1200, 32'd0);
    do_mem(1'b0, 1'b0, 5'd2, 32'd1200, 32'd0);
    do_vop(1'b0, 5'd8, 5'd2, 5'd1);
    do_mem(1'b1, 1'b1, 5'd8, 32'd800, 32'd4);
`ifdef PCPI_VEC_DOT_EN
    do_vop(1'b1, 5'd8, 5'd2, 5'd1);
    do_mem(1'b1, 1'b1, 5'd8, 32'd800, 32'd4);
`endif

    for (int r = 0; r < 16; r++) do_mem(1'b0, 1'b0, 5'(r), {18'd0, 12'($urandom_range(0, 4095)), 2'b00}, 32'd0);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      base = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      case ($urandom_range(0, 3))
        0: stride = 32'd8;
        1: stride = 32'd12;
        2: stride = 32'hffff_fffc;
        default: stride = 32'd16;
      endcase
      if (sel < 2)
        do_setvl($urandom_range(0, 11), ($urandom_range(0, 5) == 0) ? 11'h00c : 11'h008);
      else if (sel < 4)
        do_mem(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), base, stride);
      else if (sel < 6)
        do_mem(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), base, stride);
`ifdef PCPI_VEC_DOT_EN
      else if (sel < 8)
`else
      else
`endif
        do_vop(1'b0, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
`ifdef PCPI_VEC_DOT_EN
      else
        do_vop(1'b1, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
`endif
    end
    do_setvl(8, 11'h008);
    for (int r = 0; r < 16; r++) do_mem(1'b1, 1'b0, 5'(r), 32'd8192 + 32'(r) * 32'd32, 32'd0);

    // reset in the middle of a load
    for (int i = 0; i < 8; i++) begin
      mem_t e;
      e.addr = 32'd64 + 32'd4 * 32'(i);
      e.wstrb = 4'h0;
      e.wdata = 32'd0;
      exp_mem.push_back(e);
    end
    @(posedge clk); #1;
    pcpi_insn = enc_mem(1'b0, 1'b0, 5'd31, 1'b0); pcpi_cpurs1 = 32'd64; pcpi_cpurs2 = 32'd0; pcpi_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (mem_valid) got = 1'b1;
    end
    chk("abort_load_started", 32'(got), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_mem_valid", 32'(mem_valid), 32'd0);
    chk("abort_pcpi_wait", 32'(pcpi_wait), 32'd0);
    chk("abort_pcpi_ready", 32'(pcpi_ready), 32'd0);
    pcpi_valid = 1'b0;
    exp_mem.delete();
    exp_rsp.delete();
    mvl = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk("post_rst_pcpi_rd", pcpi_rd, 32'd0);
    chk("post_rst_mem_addr", mem_addr, 32'd0);
    chk("post_rst_mem_wdata", mem_wdata, 32'd0);
    do_mem(1'b0, 1'b0, 5'd3, 32'd256, 32'd0);

    repeat (10) @(posedge clk);
    chk("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
